pipe_skid_stage: RTL

- Parametrised successor to the fixed EX→MEM stage register: a generic inter-stage pipeline register for the ARM core with a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, synchronous flush and a stall counter.
- Sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB). It replaces the raw en/clr scheme with per-beat handshakes so hazard logic can stall without a combinational ready path.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 46 ++++
 rtl/pipe_skid_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
package pipe_pkg;

  // Occupancy-tracking states of the two-slot stage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  localparam int PIPE_CTRL_W = 3;
  localparam int PIPE_DEST_W = 4;
  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid + ctrl + dest + data with load/clear controls.
// Priority: rst > clr (flush) > load > drop (beat consumed, nothing new).
module pipe_slot #(
  parameter int CTRL_W   = 3,
  parameter int DEST_W   = 4,
  parameter int DATA_W   = 64,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              drop,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DEST_W-1:0] d_dest,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DEST_W-1:0] q_dest,
  output logic [DATA_W-1:0] q_data
);

  // Slot register; ctrl is zeroed whenever the slot holds no beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_dest  <= '0;
      q_data  <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_dest  <= '0;
      if (CLR_DATA) q_data <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_dest  <= d_dest;
      q_data  <= d_data;
    end else if (drop) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and saturating stall counter. in_ready is
// registered so there is no combinational path from out_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = PIPE_CTRL_W,
  parameter int DEST_W   = PIPE_DEST_W,
  parameter int DATA_W   = PIPE_DATA_W,
  parameter bit CLR_DATA = 1'b1,
  parameter int CNT_W    = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t state, state_nx;

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DEST_W-1:0] skid_dest;
  logic [DATA_W-1:0] skid_data;
  logic              main_load, main_drop, skid_load, skid_drop;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DEST_W-1:0] main_d_dest;
  logic [DATA_W-1:0] main_d_data;
  logic              acc, emit;

  assign acc  = in_valid & in_ready;
  assign emit = main_v & out_ready;

  // State register plus registered in_ready (low throughout reset)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != ST_TWO);
    end
  end

  // Next-state and slot control; flush squashes both slots
  always_comb begin
    state_nx  = state;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) begin
          main_load = 1'b1;
          state_nx  = ST_ONE;
        end
        ST_ONE: begin
          if (emit && acc)      main_load = 1'b1;
          else if (emit) begin
            main_drop = 1'b1;
            state_nx  = ST_EMPTY;
          end else if (acc) begin
            skid_load = 1'b1;
            state_nx  = ST_TWO;
          end
        end
        ST_TWO: if (emit) begin
          main_load = 1'b1;
          skid_drop = 1'b1;
          state_nx  = ST_ONE;
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  // Main refills from skid when draining TWO, otherwise from upstream
  always_comb begin
    main_d_ctrl = in_ctrl;
    main_d_dest = in_dest;
    main_d_data = in_data;
    if (state == ST_TWO) begin
      main_d_ctrl = skid_ctrl;
      main_d_dest = skid_dest;
      main_d_data = skid_data;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DEST_W(DEST_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_main (
    .clk(clk), .rst(rst), .clr(flush), .drop(main_drop), .load(main_load),
    .d_ctrl(main_d_ctrl), .d_dest(main_d_dest), .d_data(main_d_data),
    .q_valid(main_v), .q_ctrl(main_ctrl), .q_dest(out_dest), .q_data(out_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DEST_W(DEST_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_skid (
    .clk(clk), .rst(rst), .clr(flush), .drop(skid_drop), .load(skid_load),
    .d_ctrl(in_ctrl), .d_dest(in_dest), .d_data(in_data),
    .q_valid(skid_v), .q_ctrl(skid_ctrl), .q_dest(skid_dest), .q_data(skid_data)
  );

  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_v}};
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // Saturating count of upstream-blocked cycles; flush does not clear it
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule
